frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//  Per-frame controller for the double-buffered framebuffer on the GPU clock.
//  Each frame: pulses fb clear, waits for the clear sweep, releases the rasterizer,
//  waits for render done plus pipeline drain, then pulses buffer swap on the next vsync.
//  Sits between the top-level scene loop/rasterizer and the framebuffer clear/switch inputs.
// PARAMETERS
//  DRAIN_CYCLES   8   idle cycles after render_done_in before swap is armed; must be >= fb write latency (4)
//  VSYNC_ACT_LOW  1   1: vsync_in is active-low (VGA); 0: active-high
//  FRAME_W        16  width of frame_count_out
// PORTS
//  gpu_clk_in        in   1        single clock for all logic
//  rst_in            in   1        asynchronous, active-low reset
//  enable_in         in   1        level; run frames back to back while high
//  fb_ready_in       in   1        framebuffer ready (low during clear sweep)
//  vsync_in          in   1        raw VGA vsync, asynchronous; synchronized internally
//  render_done_in    in   1        1-cycle pulse from rasterizer: last fragment issued
//  fb_clear_out      out  1        1-cycle pulse to framebuffer clear
//  fb_switch_out     out  1        1-cycle pulse to framebuffer buffer switch
//  render_start_out  out  1        1-cycle pulse: rasterizer may begin the frame
//  busy_out          out  1        high in every state except IDLE
//  frame_count_out   out  FRAME_W  frames completed (swaps issued), wraps to 0
//  last_frame_cycles_out out 24    (FRAME_STATS_EN only) cycles of last frame
// BEHAVIOUR
//  Reset: state=IDLE; all pulse outputs 0, busy_out 0, frame_count_out 0, stats 0, sync flops at inactive level.
//  All outputs registered. States and transitions:
//   IDLE: enable_in=1 -> CLEAR_REQ.
//   CLEAR_REQ: only if fb_ready_in=1: fb_clear_out=1 one cycle -> CLEAR_ACK; else hold.
//   CLEAR_ACK: wait fb_ready_in=0 -> CLEAR_WAIT. (Framebuffer drops ready 1 cycle after clear.)
//   CLEAR_WAIT: fb_ready_in=1 -> RENDER with render_start_out=1 that cycle.
//   RENDER: render_done_in=1 -> DRAIN, load drain counter with DRAIN_CYCLES-1.
//     render_done_in ignored in all other states (including the start-pulse cycle).
//   DRAIN: count down; at 0 -> SYNC_WAIT.
//   SYNC_WAIT: on synced vsync inactive->active edge -> SWAP. An edge present in the
//     cycle of entry does not count; edge detector runs continuously.
//   SWAP: fb_switch_out=1 one cycle, frame_count_out+1 (FRAME_W wrap); then
//     enable_in=1 -> CLEAR_REQ, else -> IDLE.
//  enable_in dropped mid-frame: current frame completes through SWAP, then IDLE.
//  fb_clear_out and fb_switch_out never both high; each at most once per frame.
//  vsync: 2-flop synchronizer + edge register; edge-to-SWAP latency 3 cycles.
//  Reset asserted mid-frame: immediate return to reset values; no pulse emitted.
// CONFIGURATION
//  FRAME_STATS_EN defined: 24-bit cycle counter cleared on leaving IDLE/SWAP into
//   CLEAR_REQ, saturates at 24'hFFFFFF; copied to last_frame_cycles_out in SWAP.
//  Not defined: port last_frame_cycles_out absent, no counter logic.
// STRUCTURE
//  Package gfx_pkg: enum seq_state_t {IDLE, CLEAR_REQ, CLEAR_ACK, CLEAR_WAIT,
//   RENDER, DRAIN, SYNC_WAIT, SWAP}; localparams FB_WIDTH=320, FB_HEIGHT=240.
//  One sub-module: vsync_edge_sync (2-flop sync + polarity + rising-active edge pulse).
//  FSM, drain counter, frame counter, stats counter in frame_sequencer.
// TESTING
//  1 Reset low mid-RENDER -> next cycle all outputs 0, frame_count_out=0, busy_out=0.
//  2 enable=1, fb model drops ready 1 cycle after clear for 76800 cycles ->
//    exactly one fb_clear_out, render_start_out 1 cycle after ready rises.
//  3 render_done at cycle T, DRAIN_CYCLES=8, vsync edge at T+2 -> ignored; next edge
//    E -> fb_switch_out at E+3, frame_count_out 0->1.
//  4 enable dropped during DRAIN -> frame finishes, one switch, then IDLE, busy_out=0.
//  5 frame_count preset 16'hFFFF via 65535 fast frames (short vsync period) -> wraps to 0.
//  6 FRAME_STATS_EN: frame of known length N cycles -> last_frame_cycles_out=N at SWAP+1.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared types and constants for the graphics frame pipeline.
// Holds the frame sequencer state encoding and framebuffer geometry.
package gfx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_REQ,
        CLEAR_ACK,
        CLEAR_WAIT,
        RENDER,
        DRAIN,
        SYNC_WAIT,
        SWAP
    } seq_state_t;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    localparam int          STATS_W   = 24;
    localparam logic [23:0] STATS_MAX = 24'hFFFFFF;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the raw asynchronous vsync into the GPU clock domain and emits a
// one-cycle pulse on each inactive->active transition, for either polarity.
module vsync_edge_sync
    import gfx_pkg::*;
#(
    parameter int VSYNC_ACT_LOW = 1
) (
    input  logic gpu_clk_in,
    input  logic rst_in,
    input  logic vsync_in,
    output logic vsync_edge
);

    localparam logic INACTIVE = (VSYNC_ACT_LOW != 0);

    logic sync1, sync2, sync_prev;

    // Flops reset to the idle line level so leaving reset never fakes an edge.
    always_ff @(posedge gpu_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1     <= INACTIVE;
            sync2     <= INACTIVE;
            sync_prev <= INACTIVE;
        end else begin
            sync1     <= vsync_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign vsync_edge = (sync2 ^ INACTIVE) & ~(sync_prev ^ INACTIVE);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: clear -> render -> drain -> swap on vsync, all outputs registered.
// Define FRAME_STATS_EN to add the last_frame_cycles_out frame-length counter.
module frame_sequencer
    import gfx_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 8,
    parameter int VSYNC_ACT_LOW = 1,
    parameter int FRAME_W       = 16
) (
    input  logic               gpu_clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               fb_ready_in,
    input  logic               vsync_in,
    input  logic               render_done_in,
    output logic               fb_clear_out,
    output logic               fb_switch_out,
    output logic               render_start_out,
    output logic               busy_out,
    output logic [FRAME_W-1:0] frame_count_out
`ifdef FRAME_STATS_EN
    ,
    output logic [STATS_W-1:0] last_frame_cycles_out
`endif
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    seq_state_t         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               sync_armed_q, sync_armed_d;
    logic               fb_clear_d, fb_switch_d, render_start_d, busy_d;
    logic [FRAME_W-1:0] frame_count_d;
    logic               vsync_edge;

    vsync_edge_sync #(
        .VSYNC_ACT_LOW(VSYNC_ACT_LOW)
    ) u_vsync_edge_sync (
        .gpu_clk_in(gpu_clk_in),
        .rst_in    (rst_in),
        .vsync_in  (vsync_in),
        .vsync_edge(vsync_edge)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d        = state_q;
        drain_d        = drain_q;
        sync_armed_d   = 1'b0;
        fb_clear_d     = 1'b0;
        fb_switch_d    = 1'b0;
        render_start_d = 1'b0;
        frame_count_d  = frame_count_out;
        unique case (state_q)
            IDLE: if (enable_in) state_d = CLEAR_REQ;
            CLEAR_REQ: if (fb_ready_in) begin
                fb_clear_d = 1'b1;
                state_d    = CLEAR_ACK;
            end
            CLEAR_ACK: if (!fb_ready_in) state_d = CLEAR_WAIT;
            CLEAR_WAIT: if (fb_ready_in) begin
                render_start_d = 1'b1;
                state_d        = RENDER;
            end
            // A done pulse coinciding with our own start pulse belongs to a stale frame.
            RENDER: if (render_done_in && !render_start_out) begin
                drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == '0) state_d = SYNC_WAIT;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            // The armed flag masks an edge already in flight on the entry cycle.
            SYNC_WAIT: begin
                sync_armed_d = 1'b1;
                if (vsync_edge && sync_armed_q) begin
                    fb_switch_d   = 1'b1;
                    frame_count_d = frame_count_out + FRAME_W'(1);
                    state_d       = SWAP;
                end
            end
            SWAP:    state_d = enable_in ? CLEAR_REQ : IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge gpu_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= IDLE;
            drain_q          <= '0;
            sync_armed_q     <= 1'b0;
            fb_clear_out     <= 1'b0;
            fb_switch_out    <= 1'b0;
            render_start_out <= 1'b0;
            busy_out         <= 1'b0;
            frame_count_out  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q          <= state_d;
            drain_q          <= drain_d;
            sync_armed_q     <= sync_armed_d;
            fb_clear_out     <= fb_clear_d;
            fb_switch_out    <= fb_switch_d;
            render_start_out <= render_start_d;
            busy_out         <= busy_d;
            frame_count_out  <= frame_count_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [STATS_W-1:0] stats_cnt;

    always_ff @(posedge gpu_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stats_cnt             <= '0;
            last_frame_cycles_out <= '0;
        end else begin
            if (state_d == CLEAR_REQ && (state_q == IDLE || state_q == SWAP))
                stats_cnt <= '0;
            else if (stats_cnt != STATS_MAX)
                stats_cnt <= stats_cnt + STATS_W'(1);
            if (state_q == SWAP)
                last_frame_cycles_out <= stats_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized self-checking bench for frame_sequencer with a timeline reference model.
// Expected event cycles are derived from the frame rules, not from the RTL state machine.
module tb_frame_sequencer;

    localparam int DRAIN = 8;
    localparam int FW    = 4;
    localparam int STALL = 3;

    logic          gpu_clk_in     = 1'b0;
    logic          rst_in         = 1'b0;
    logic          enable_in      = 1'b0;
    logic          fb_ready_in    = 1'b1;
    logic          vsync_in       = 1'b1;
    logic          render_done_in = 1'b0;
    logic          fb_clear_out, fb_switch_out, render_start_out, busy_out;
    logic [FW-1:0] frame_count_out;
`ifdef FRAME_STATS_EN
    logic [23:0]   last_frame_cycles_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_clear = 0, n_switch = 0, n_start = 0, n_overlap = 0;
    int frames_started = 0, frames_done = 0, exp_frames = 0;

    frame_sequencer #(
        .DRAIN_CYCLES (DRAIN),
        .VSYNC_ACT_LOW(1),
        .FRAME_W      (FW)
    ) dut (
        .gpu_clk_in      (gpu_clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .fb_ready_in     (fb_ready_in),
        .vsync_in        (vsync_in),
        .render_done_in  (render_done_in),
        .fb_clear_out    (fb_clear_out),
        .fb_switch_out   (fb_switch_out),
        .render_start_out(render_start_out),
        .busy_out        (busy_out),
        .frame_count_out (frame_count_out)
`ifdef FRAME_STATS_EN
        ,
        .last_frame_cycles_out(last_frame_cycles_out)
`endif
    );

    always #5 gpu_clk_in = ~gpu_clk_in;
    always @(posedge gpu_clk_in) cyc++;

    // Pulse counters sampled mid-cycle.
    always @(negedge gpu_clk_in) begin
        if (fb_clear_out)                  n_clear++;
        if (fb_switch_out)                 n_switch++;
        if (render_start_out)              n_start++;
        if (fb_clear_out && fb_switch_out) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge gpu_clk_in);
        #1;
    endtask

    // One complete frame; CLEAR_REQ is entered at cycle creq. Returns one cycle after the swap.
    task automatic run_frame(input int creq, input int sweep, input int rlen,
                             input bit stall, input bit drop);
        int q, clr_t, clr_exp, t_done, x_real, s;
        bit seen, bad, bnd;
        q = cyc;
        if (stall) fb_ready_in = 1'b0;
        clr_exp = stall ? ((creq + 1 > q + STALL + 1) ? creq + 1 : q + STALL + 1) : creq + 1;
        seen  = 1'b0;
        clr_t = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (fb_clear_out) begin
                seen  = 1'b1;
                clr_t = cyc;
            end else if (stall && cyc == q + STALL) begin
                fb_ready_in = 1'b1;
            end
        end
        check("clear_seen", 32'(seen), 1);
        check("clear_cycle", clr_t, clr_exp);
        frames_started++;

        // Framebuffer model: ready drops right after the clear pulse for the sweep.
        fb_ready_in = 1'b0;
        bad = 1'b0;
        for (int i = 1; i <= sweep; i++) begin
            tick();
            if (fb_clear_out || render_start_out) bad = 1'b1;
        end
        check("sweep_quiet", 32'(bad), 0);
        fb_ready_in = 1'b1;
        tick();
        check("render_start", 32'(render_start_out), 1);
        render_done_in = 1'b1;
        tick();
        render_done_in = 1'b0;
        check("start_pulse_1cyc", 32'(render_start_out), 0);
        for (int i = 0; i < rlen; i++) tick();

        // Swap lands 3 cycles after the first vsync edge no earlier than DRAIN after done.
        render_done_in = 1'b1;
        t_done = cyc;
        bnd    = 1'($urandom_range(0, 1));
        x_real = DRAIN + int'(bnd) + int'($urandom_range(0, 6));
        bad    = 1'b0;
        for (int rel = 1; rel <= x_real + 3; rel++) begin
            tick();
            render_done_in = 1'b0;
            vsync_in = !((rel == 2) || (bnd && rel == DRAIN - 1) || (rel == x_real));
            if (drop && rel == 4) enable_in = 1'b0;
            if (rel < x_real + 3 && fb_switch_out) bad = 1'b1;
        end
        check("switch_early", 32'(bad), 0);
        check("switch", 32'(fb_switch_out), 1);
        check("switch_cycle", cyc - t_done, x_real + 3);
        exp_frames = (exp_frames + 1) % (1 << FW);
        frames_done++;
        check("frame_count", 32'(frame_count_out), exp_frames);
        check("busy_swap", 32'(busy_out), 1);
        s = cyc;
        tick();
        check("switch_pulse_1cyc", 32'(fb_switch_out), 0);
        check("busy_after_swap", 32'(busy_out), drop ? 0 : 1);
`ifdef FRAME_STATS_EN
        check("frame_cycles", last_frame_cycles_out, s - creq);
`endif
        check("clear_count", n_clear, frames_started);
        check("switch_count", n_switch, frames_done);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int q;
        bit seen;

        repeat (3) tick();
        check("rst_outputs", {fb_clear_out, fb_switch_out, render_start_out, busy_out}, 0);
        check("rst_count", 32'(frame_count_out), 0);
        rst_in = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(busy_out), 0);
        check("idle_no_clear", n_clear, 0);

        // Long first clear sweep, then back-to-back randomized frames through a count wrap.
        enable_in = 1'b1;
        q = cyc;
        run_frame(q + 1, 300, 5, 1'b0, 1'b0);
        for (int f = 0; f < 18; f++)
            run_frame(cyc, int'($urandom_range(1, 40)), int'($urandom_range(1, 30)),
                      1'($urandom_range(0, 1)), 1'b0);

        // Enable dropped while draining: frame finishes, then idle with no new clear.
        run_frame(cyc, 10, 4, 1'b0, 1'b1);
        repeat (5) tick();
        check("drop_idle_busy", 32'(busy_out), 0);
        check("drop_no_clear", n_clear, frames_started);

        // Reset asserted mid-RENDER.
        enable_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = fb_clear_out;
        end
        frames_started++;
        fb_ready_in = 1'b0;
        repeat (5) tick();
        fb_ready_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = render_start_out;
        end
        check("rstmid_render_started", 32'(seen), 1);
        repeat (2) tick();
        check("rstmid_busy_before", 32'(busy_out), 1);
        #2 rst_in = 1'b0;
        #1;
        check("rstmid_async", {fb_clear_out, fb_switch_out, render_start_out, busy_out}, 0);
        check("rstmid_count", 32'(frame_count_out), 0);
        enable_in = 1'b0;
        tick();
        check("rstmid_next", {fb_clear_out, fb_switch_out, render_start_out, busy_out}, 0);
        rst_in = 1'b1;
        exp_frames = 0;
        repeat (4) tick();
        check("rstmid_idle", {busy_out, 4'(frame_count_out)}, 0);
        check("rstmid_no_switch", n_switch, frames_done);

        enable_in = 1'b1;
        q = cyc;
        run_frame(q + 1, 12, 6, 1'b0, 1'b1);
        check("post_rst_count", 32'(frame_count_out), 1);
        check("clear_switch_exclusive", n_overlap, 0);
        check("start_count", n_start, frames_started);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
